// File: rtl/is_uart_tx.sv
// UART serial transmitter: accepts one DATA_W-bit word per request and sends
// start, LSB-first data, optional parity and stop bits, then pulses done.
`timescale 1ns/1ps
module is_uart_tx #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int DATA_W     = 8,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              tx_rdy_t_i,
  input  logic [DATA_W-1:0] tx_data_t_i,
  output logic              tx_rdy_r_o,
  output logic              tx_o,
  output logic              busy_o
);

  localparam int CPB     = CLK_FREQ / BAUD;
  localparam int CNT_W   = $clog2(CPB);
  localparam int IDX_MAX = (DATA_W > STOP_BITS) ? DATA_W : STOP_BITS;
  localparam int IDX_W   = (IDX_MAX > 1) ? $clog2(IDX_MAX) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CPB - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_W - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic [DATA_W-1:0]  shift_next;
  logic               parity_q, parity_d;
  logic               tx_q, tx_d;
  logic               rdy_q, rdy_d;
  logic               busy_q, busy_d;
  logic               bit_end;

  // tx_d is the line value for the state being entered, so the line is
  // registered and changes on the same edge as the state.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    tx_d       = tx_q;
    rdy_d      = 1'b0;
    busy_d     = busy_q;
    bit_end    = (cnt_q == CNT_LAST);
    shift_next = shift_q >> 1;

    case (state_q)
      S_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        cnt_d  = '0;
        idx_d  = '0;
        if (tx_rdy_t_i) begin
          shift_d  = tx_data_t_i;
          parity_d = (^tx_data_t_i) ^ (PARITY_ODD != 0);
          state_d  = S_START;
          tx_d     = 1'b0;
          busy_d   = 1'b1;
        end
      end
      S_START: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (bit_end) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = S_DATA;
          tx_d    = shift_q[0];
        end
      end
      S_DATA: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (bit_end) begin
          cnt_d = '0;
          if (idx_q == DATA_LAST) begin
            idx_d = '0;
            if (PARITY_EN != 0) begin
              state_d = S_PARITY;
              tx_d    = parity_q;
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            shift_d = shift_next;
            tx_d    = shift_next[0];
          end
        end
      end
      S_PARITY: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (bit_end) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = S_STOP;
          tx_d    = 1'b1;
        end
      end
      S_STOP: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (bit_end) begin
          cnt_d = '0;
          if (idx_q == STOP_LAST) begin
            idx_d   = '0;
            state_d = S_DONE;
            rdy_d   = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
          tx_d = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        cnt_d   = '0;
        idx_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rstn_i) begin
    if (rstn_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      tx_q     <= 1'b1;
      rdy_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      tx_q     <= tx_d;
      rdy_q    <= rdy_d;
      busy_q   <= busy_d;
    end
  end

  assign tx_o       = tx_q;
  assign tx_rdy_r_o = rdy_q;
  assign busy_o     = busy_q;

endmodule

// File: tb/tb_is_uart_tx.sv
// Bench for is_uart_tx: three instances (even parity, odd parity, no parity)
// driven with directed and random frames, checked against a frame-level model.
`timescale 1ns/1ps
module tb_is_uart_tx;

  localparam int CPB = 10;

  logic       clk;
  logic       rst;
  logic       req    [3];
  logic [7:0] din    [3];
  logic       rdy_w  [3];
  logic       tx_w   [3];
  logic       busy_w [3];

  int  checks;
  int  errors;
  int  done_cnt [3];
  int  double_cnt;
  bit  prev_rdy [3];

  bit pe_cfg [3] = '{1'b1, 1'b1, 1'b0};
  bit po_cfg [3] = '{1'b0, 1'b1, 1'b0};

  is_uart_tx #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_W(8),
               .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_even (
    .clk_i(clk), .rstn_i(rst), .tx_rdy_t_i(req[0]), .tx_data_t_i(din[0]),
    .tx_rdy_r_o(rdy_w[0]), .tx_o(tx_w[0]), .busy_o(busy_w[0]));

  is_uart_tx #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_W(8),
               .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_odd (
    .clk_i(clk), .rstn_i(rst), .tx_rdy_t_i(req[1]), .tx_data_t_i(din[1]),
    .tx_rdy_r_o(rdy_w[1]), .tx_o(tx_w[1]), .busy_o(busy_w[1]));

  is_uart_tx #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_W(8),
               .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_nopar (
    .clk_i(clk), .rstn_i(rst), .tx_rdy_t_i(req[2]), .tx_data_t_i(din[2]),
    .tx_rdy_r_o(rdy_w[2]), .tx_o(tx_w[2]), .busy_o(busy_w[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Done-pulse monitor on the falling edge, away from the active edge.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rdy_w[k] === 1'b1) begin
        done_cnt[k]++;
        if (prev_rdy[k]) double_cnt++;
      end
      prev_rdy[k] = (rdy_w[k] === 1'b1);
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL timeout: simulation exceeded time limit");
    $fatal(1, "[TB] timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sends one frame from an IDLE cycle; leaves the bench in the IDLE cycle
  // following DONE. The expected line is built bit by bit from the frame rules.
  task automatic applyStimulus(input int k, input logic [7:0] d, input bit drop_req,
                               input int chg_cycle, input logic [7:0] chg_val,
                               input bit has_next, input logic [7:0] next_d);
    logic       bits [$];
    logic [7:0] rx;
    int         cyc;
    int         start_done;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (pe_cfg[k]) bits.push_back((^d) ^ po_cfg[k]);
    bits.push_back(1'b1);

    din[k] = d;
    req[k] = 1'b1;
    start_done = done_cnt[k];
    step();
    if (drop_req) req[k] = 1'b0;
    checkOutput($sformatf("k%0d_busy_accept", k), busy_w[k], 1);
    rx  = '0;
    cyc = 0;
    for (int b = 0; b < bits.size(); b++) begin
      for (int c = 0; c < CPB; c++) begin
        if (cyc == chg_cycle) din[k] = chg_val;
        checkOutput($sformatf("k%0d_tx_bit%0d_c%0d", k, b, c), tx_w[k], bits[b]);
        if (c == 0) begin
          checkOutput($sformatf("k%0d_rdy_low_bit%0d", k, b), rdy_w[k], 0);
          checkOutput($sformatf("k%0d_busy_bit%0d", k, b), busy_w[k], 1);
        end
        if (c == CPB / 2 && b >= 1 && b <= 8) rx[b-1] = tx_w[k];
        step();
        cyc++;
      end
    end
    checkOutput($sformatf("k%0d_done_rdy", k), rdy_w[k], 1);
    checkOutput($sformatf("k%0d_done_tx", k), tx_w[k], 1);
    checkOutput($sformatf("k%0d_done_busy", k), busy_w[k], 1);
    checkOutput($sformatf("k%0d_rx_byte", k), rx, d);
    if (has_next) din[k] = next_d;
    step();
    checkOutput($sformatf("k%0d_idle_rdy", k), rdy_w[k], 0);
    checkOutput($sformatf("k%0d_idle_tx", k), tx_w[k], 1);
    checkOutput($sformatf("k%0d_idle_busy", k), busy_w[k], 0);
    checkOutput($sformatf("k%0d_done_count", k), done_cnt[k] - start_done, 1);
  endtask

  initial begin
    int saved;
    logic [7:0] rd;
    checks = 0;
    errors = 0;
    double_cnt = 0;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      req[k] = 1'b0;
      din[k] = '0;
    end
    step();
    step();
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("k%0d_rst_tx", k), tx_w[k], 1);
      checkOutput($sformatf("k%0d_rst_rdy", k), rdy_w[k], 0);
      checkOutput($sformatf("k%0d_rst_busy", k), busy_w[k], 0);
    end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (i % 5 == 0) begin
        checkOutput("idle_tx_high", tx_w[0], 1);
        checkOutput("idle_not_busy", busy_w[0], 0);
      end
    end

    $display("[TB] single frame A5, even parity");
    applyStimulus(0, 8'hA5, 1, -1, 8'h00, 0, 8'h00);

    $display("[TB] data 03 with odd parity and without parity");
    applyStimulus(1, 8'h03, 1, -1, 8'h00, 0, 8'h00);
    applyStimulus(2, 8'h03, 1, -1, 8'h00, 0, 8'h00);

    $display("[TB] back-to-back message 31 0D 0A");
    saved = done_cnt[0];
    applyStimulus(0, 8'h31, 0, -1, 8'h00, 1, 8'h0D);
    applyStimulus(0, 8'h0D, 0, -1, 8'h00, 1, 8'h0A);
    applyStimulus(0, 8'h0A, 1, -1, 8'h00, 0, 8'h00);
    checkOutput("b2b_done_total", done_cnt[0] - saved, 3);

    $display("[TB] data change mid-frame");
    applyStimulus(0, 8'h55, 1, 20, 8'hFF, 0, 8'h00);

    $display("[TB] reset mid-frame");
    din[0] = 8'h00;
    req[0] = 1'b1;
    saved  = done_cnt[0];
    step();
    for (int i = 0; i < 4 * CPB + 4; i++) step();
    checkOutput("pre_reset_tx_low", tx_w[0], 0);
    rst = 1'b1;
    #1;
    checkOutput("reset_async_tx", tx_w[0], 1);
    checkOutput("reset_async_busy", busy_w[0], 0);
    checkOutput("reset_async_rdy", rdy_w[0], 0);
    step();
    step();
    rst = 1'b0;
    checkOutput("reset_no_done", done_cnt[0] - saved, 0);
    applyStimulus(0, 8'hC3, 1, -1, 8'h00, 0, 8'h00);

    $display("[TB] random frames");
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 4; i++) begin
        rd = 8'($urandom_range(0, 255));
        applyStimulus(k, rd, 1'($urandom_range(0, 1)), -1, 8'h00, 0, 8'h00);
      end
      req[k] = 1'b0;
      step();
    end

    checkOutput("no_double_done", double_cnt, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/is_uart_tx.md
# is_uart_tx

UART serial transmitter for the UART controller lab design. It sits directly downstream of the controller FSM. It takes one byte at a time over the `tx_rdy_t` / `tx_data_t` request interface, serialises it onto the TX line, and returns a one-cycle `tx_rdy_r` completion pulse that tells the FSM to present the next byte. The frame format is start bit, LSB-first data, optional parity, and stop bit(s).

## Interface
Parameters:
- `CLK_FREQ`, default 50_000_000: system clock frequency in Hz.
- `BAUD`, default 115200: line rate. `CPB = CLK_FREQ / BAUD` (integer division) is the number of clocks per bit; CPB ≥ 2.
- `DATA_W`, default 8: data bits per frame.
- `PARITY_EN`, default 1: 1 inserts a parity bit after the data bits.
- `PARITY_ODD`, default 0: 0 selects even parity, 1 selects odd parity.
- `STOP_BITS`, default 1: number of stop bits, 1 or 2.

Ports:
- `clk_i`, in, 1: system clock, rising edge.
- `rstn_i`, in, 1: reset. One clock; reset is asynchronous and active-high (asserted when `rstn_i` = 1, acting on its rising edge).
- `tx_rdy_t_i`, in, 1: transmit request, level-sensitive. The FSM holds it high for the whole message.
- `tx_data_t_i`, in, `DATA_W`: byte to send. Sampled only at frame acceptance.
- `tx_rdy_r_o`, out, 1: frame-done pulse, exactly one cycle per frame.
- `tx_o`, out, 1: serial line, idles high. Registered.
- `busy_o`, out, 1: high from acceptance through the DONE cycle.

## Operation
- States: IDLE, START, DATA, PARITY, STOP, DONE. A single bit counter `bit_cnt` runs 0..CPB-1, and an index counter selects the data bit or stop bit.
- **IDLE:** `tx_o` = 1, `busy_o` = 0. If `tx_rdy_t_i` = 1:
  - latch `tx_data_t_i` into the shift register;
  - compute parity = XOR of the data, inverted when `PARITY_ODD`;
  - go to START.
- **START:** `tx_o` = 0 for CPB cycles, then DATA.
- **DATA:** shift register LSB first, each bit held for CPB cycles. After `DATA_W` bits, go to PARITY if `PARITY_EN`, else STOP.
- **PARITY:** `tx_o` = parity bit for CPB cycles, then STOP.
- **STOP:** `tx_o` = 1 for `STOP_BITS`×CPB cycles, then DONE.
- **DONE:** one cycle. `tx_rdy_r_o` = 1, `tx_o` = 1. Unconditionally return to IDLE.
- Frame length = (1 + `DATA_W` + `PARITY_EN` + `STOP_BITS`)×CPB cycles of START..STOP.
- Boundary rules:
  - Deasserting `tx_rdy_t_i` mid-frame does not abort. The frame completes and DONE still pulses.
  - Changes to `tx_data_t_i` after acceptance have no effect on the frame in flight.
  - `tx_rdy_t_i` still high in IDLE after DONE means a new frame is accepted with the data present in that IDLE cycle. The FSM updates `tx_data_t_i` in the DONE cycle, so the new byte is visible in IDLE.
  - Reset mid-frame: `tx_o` goes to 1 immediately (asynchronously). The state returns to IDLE and the counters clear. No DONE pulse is produced for the aborted frame.
  - Request and reset release on the same edge: the request is first sampled on the next edge.

## Timing
- Reset values: `tx_o` = 1, `tx_rdy_r_o` = 0, `busy_o` = 0, state = IDLE, all counters = 0, shift register = 0.
- Request seen high at edge N (in IDLE):
  - `busy_o` = 1 and `tx_o` = 0 from edge N+1;
  - the first data bit appears at N+1+CPB.
- Last stop-bit cycle ends at edge M. `tx_rdy_r_o` is high for cycle M..M+1 only.
- Back-to-back frames: the line stays high for `STOP_BITS`×CPB + 2 cycles between frames (DONE + IDLE). The next start bit begins 2 cycles after the stop bit ends.
- Bit edges occur exactly every CPB clocks, with no cumulative drift inside a frame.
- `tx_rdy_r_o` never asserts in two consecutive cycles.

## Test plan
All scenarios use `CLK_FREQ` = 1_000_000, `BAUD` = 100_000 (CPB = 10), `DATA_W` = 8, `STOP_BITS` = 1.
- **Reset check:** assert `rstn_i` = 1 → `tx_o` = 1, `tx_rdy_r_o` = 0, `busy_o` = 0. Release with `tx_rdy_t_i` = 0 → line stays high indefinitely.
- **Single frame, even parity:** `tx_rdy_t_i` = 1, data 8'hA5, `PARITY_EN` = 1, `PARITY_ODD` = 0, request dropped after acceptance →
  - line pattern 0,1,0,1,0,0,1,0,1,0,1, each bit 10 cycles;
  - one `tx_rdy_r_o` pulse 110 cycles after `tx_o` falls.
- **Odd parity / no parity:** data 8'h03.
  - With `PARITY_ODD` = 1, parity bit = 1.
  - With `PARITY_EN` = 0, the frame is 100 cycles and the stop bit follows bit 7 directly.
- **Back-to-back message:** FSM model holds request high and updates data on each done pulse: 8'h31, 8'h0D, 8'h0A →
  - three frames, three done pulses;
  - 12 high cycles between consecutive start bits' preceding stop-bit start and next start bit (10 stop + 2);
  - a receiver model decodes 31, 0D, 0A.
- **Data change mid-frame:** accept 8'h55, drive `tx_data_t_i` = 8'hFF from cycle 20 → the transmitted data bits still decode 8'h55.
- **Reset mid-frame:** assert `rstn_i` during data bit 3 of 8'h00 → `tx_o` = 1 before the next clock edge and no done pulse. After release with request high, a fresh complete frame is sent.
